// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction buffer: DEPTH-entry circular FIFO of {pc, inst, except}
// with full and head-preserving flush. Optional same-cycle bypass: define IFID_BYPASS_EN.
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int EXC_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     keep_head,
  input  logic                     stall_id,
  input  logic                     if_valid,
  input  logic [31:0]              if_pc,
  input  logic [31:0]              if_inst,
  input  logic [EXC_W-1:0]         if_except,
  output logic                     if_ready,
  output logic                     id_valid,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_inst,
  output logic [EXC_W-1:0]         id_except,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [EXC_W-1:0] except;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
  logic [CNT_W-1:0]   count, count_n;
  logic               head_valid, head_pop, bypass, push;

  // Handshake: fetch transfers when if_valid && if_ready (and no flush); decode
  // consumes the head when id_valid && !stall_id. if_ready is registered-state only.
  assign if_ready   = rst_n && (count < FULL);
  assign head_valid = (count != '0);
  assign head_pop   = head_valid && !stall_id;
  assign occupancy  = count;

`ifdef IFID_BYPASS_EN
  assign bypass = rst_n && !head_valid && if_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed instruction that decode takes this cycle is never written.
  assign push     = if_valid && if_ready && !flush && !(bypass && !stall_id);
  assign id_valid = head_valid || bypass;

  always_comb begin
    id_pc     = '0;
    id_inst   = '0;
    id_except = '0;
    if (head_valid) begin
      id_pc     = mem[rd_ptr].pc;
      id_inst   = mem[rd_ptr].inst;
      id_except = mem[rd_ptr].except;
    end else if (bypass) begin
      id_pc     = if_pc;
      id_inst   = if_inst;
      id_except = if_except;
    end
  end

  always_comb begin
    rd_ptr_n = rd_ptr;
    wr_ptr_n = wr_ptr;
    count_n  = count;
    if (flush) begin
      if (keep_head && head_valid) begin
        // Only the head (delay slot) survives; new writes land right behind it.
        wr_ptr_n = rd_ptr + 1'b1;
        if (head_pop) begin
          rd_ptr_n = rd_ptr + 1'b1;
          count_n  = '0;
        end else begin
          count_n  = CNT_W'(1);
        end
      end else begin
        rd_ptr_n = '0;
        wr_ptr_n = '0;
        count_n  = '0;
      end
    end else begin
      if (push)     wr_ptr_n = wr_ptr + 1'b1;
      if (head_pop) rd_ptr_n = rd_ptr + 1'b1;
      case ({push, head_pop})
        2'b10:   count_n = count + CNT_W'(1);
        2'b01:   count_n = count - CNT_W'(1);
        default: count_n = count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_n;
      wr_ptr <= wr_ptr_n;
      count  <= count_n;
    end
  end

  // Storage is unreset; stale contents are hidden because outputs are gated by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: if_pc, inst: if_inst, except: if_except};
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: vector table for fill/drain/flush cases plus
// hand-written sequences for async reset, continuous push/pop across wrap, and bypass.
module tb_if_id_queue;

  localparam int DEPTH = 4;
  localparam int EXC_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0, keep_head = 1'b0, stall_id = 1'b1, if_valid = 1'b0;
  logic [31:0]       if_pc = '0, if_inst = '0;
  logic [EXC_W-1:0]  if_except = '0;
  logic              if_ready, id_valid;
  logic [31:0]       id_pc, id_inst;
  logic [EXC_W-1:0]  id_except;
  logic [$clog2(DEPTH):0] occupancy;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  if_id_queue #(.DEPTH(DEPTH), .EXC_W(EXC_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .keep_head(keep_head), .stall_id(stall_id),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .if_except(if_except),
    .if_ready(if_ready), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .id_except(id_except), .occupancy(occupancy)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        f, k, s, v;
    logic [31:0] pc;
    logic        e_valid;
    logic [31:0] e_pc;
    int          e_occ;
    logic        e_ready;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic f, logic k, logic s, logic v, logic [31:0] pc,
                              logic ev, logic [31:0] epc, int eocc, logic erdy);
    vec_t t;
    t.f = f; t.k = k; t.s = s; t.v = v; t.pc = pc;
    t.e_valid = ev; t.e_pc = epc; t.e_occ = eocc; t.e_ready = erdy;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic f, input logic k, input logic s, input logic v,
                       input logic [31:0] pc);
    flush = f; keep_head = k; stall_id = s; if_valid = v;
    if_pc = pc; if_inst = ~pc; if_except = pc[15:0];
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
  endtask

  // Advance one edge, then return inputs to idle so checks see registered state only.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic chk_head(input string name, input logic ev, input logic [31:0] epc,
                          input int eocc, input logic erdy);
    chk({name, " id_valid"},  {31'b0, id_valid}, {31'b0, ev});
    chk({name, " id_pc"},     id_pc, ev ? epc : 32'h0);
    chk({name, " id_inst"},   id_inst, ev ? ~epc : 32'h0);
    chk({name, " id_except"}, {16'b0, id_except}, ev ? {16'b0, epc[15:0]} : 32'h0);
    chk({name, " occupancy"}, 32'(occupancy), 32'(eocc));
    chk({name, " if_ready"},  {31'b0, if_ready}, {31'b0, erdy});
  endtask

  // Scoreboard-backed cycle for the continuous push/pop sequence.
  task automatic sb_cycle(input logic s, input logic v, input logic [31:0] pc);
    logic do_pop, do_push;
    do_pop  = (exp_q.size() != 0) && !s;
    do_push = v && (exp_q.size() < DEPTH);
    drive(1'b0, 1'b0, s, v, pc);
    if (do_pop)  void'(exp_q.pop_front());
    if (do_push) exp_q.push_back(pc);
    step();
    chk("sb occupancy", 32'(occupancy), 32'(exp_q.size()));
    chk("sb id_valid", {31'b0, id_valid}, {31'b0, (exp_q.size() != 0)});
    if (exp_q.size() != 0) chk("sb id_pc", id_pc, exp_q[0]);
  endtask

  initial begin
    logic [31:0] prev_pc;

    // Fill/drain, full flush, keep-head flush (stalled and popping), keep-head on empty.
    vecs.push_back(mk(0,0,1,1,32'h80000000, 1,32'h80000000,1,1));
    vecs.push_back(mk(0,0,1,1,32'h80000004, 1,32'h80000000,2,1));
    vecs.push_back(mk(0,0,1,1,32'h80000008, 1,32'h80000000,3,1));
    vecs.push_back(mk(0,0,1,1,32'h8000000C, 1,32'h80000000,4,0));
    vecs.push_back(mk(0,0,1,1,32'h80000010, 1,32'h80000000,4,0));
    vecs.push_back(mk(0,0,0,0,32'h0,        1,32'h80000004,3,1));
    vecs.push_back(mk(0,0,0,0,32'h0,        1,32'h80000008,2,1));
    vecs.push_back(mk(0,0,0,0,32'h0,        1,32'h8000000C,1,1));
    vecs.push_back(mk(0,0,0,0,32'h0,        0,32'h0,0,1));
    vecs.push_back(mk(0,0,1,1,32'h800000A0, 1,32'h800000A0,1,1));
    vecs.push_back(mk(0,0,1,1,32'h800000A4, 1,32'h800000A0,2,1));
    vecs.push_back(mk(0,0,1,1,32'h800000A8, 1,32'h800000A0,3,1));
    vecs.push_back(mk(1,0,1,1,32'h800000AC, 0,32'h0,0,1));
    vecs.push_back(mk(0,0,1,0,32'h0,        0,32'h0,0,1));
    vecs.push_back(mk(0,0,1,1,32'h80000104, 1,32'h80000104,1,1));
    vecs.push_back(mk(0,0,1,1,32'h80000108, 1,32'h80000104,2,1));
    vecs.push_back(mk(0,0,1,1,32'h8000010C, 1,32'h80000104,3,1));
    vecs.push_back(mk(1,1,1,1,32'h80002222, 1,32'h80000104,1,1));
    vecs.push_back(mk(0,0,1,1,32'h80002000, 1,32'h80000104,2,1));
    vecs.push_back(mk(0,0,0,0,32'h0,        1,32'h80002000,1,1));
    vecs.push_back(mk(0,0,0,0,32'h0,        0,32'h0,0,1));
    vecs.push_back(mk(0,0,1,1,32'h80000300, 1,32'h80000300,1,1));
    vecs.push_back(mk(0,0,1,1,32'h80000304, 1,32'h80000300,2,1));
    vecs.push_back(mk(1,1,0,0,32'h0,        0,32'h0,0,1));
    vecs.push_back(mk(0,0,1,1,32'h80000400, 1,32'h80000400,1,1));
    vecs.push_back(mk(0,0,0,0,32'h0,        0,32'h0,0,1));
    vecs.push_back(mk(1,1,0,1,32'h80000500, 0,32'h0,0,1));
    vecs.push_back(mk(0,0,1,1,32'h80000600, 1,32'h80000600,1,1));
    vecs.push_back(mk(0,0,0,0,32'h0,        0,32'h0,0,1));

    // Reset state while rst_n is held low.
    #2;
    chk_head("reset", 1'b0, 32'h0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_head("post-reset", 1'b0, 32'h0, 0, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].f, vecs[i].k, vecs[i].s, vecs[i].v, vecs[i].pc);
      step();
      chk_head($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc,
               vecs[i].e_occ, vecs[i].e_ready);
    end

    // Asynchronous reset with three entries queued.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h80000700 + 32'(4 * i));
      step();
    end
    chk("pre-reset occupancy", 32'(occupancy), 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    chk_head("async reset", 1'b0, 32'h0, 0, 1'b0);
    @(posedge clk);
    #1;
    chk_head("reset held", 1'b0, 32'h0, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_head("reset release", 1'b0, 32'h0, 0, 1'b1);

    // Hold two entries with continuous push and pop across the pointer wrap.
    exp_q.delete();
    sb_cycle(1'b1, 1'b1, 32'h00002000);
    sb_cycle(1'b1, 1'b1, 32'h00002004);
    prev_pc = id_pc;
    for (int i = 0; i < 10; i++) begin
      sb_cycle(1'b0, 1'b1, 32'h00002008 + 32'(4 * i));
      chk("wrap occupancy", 32'(occupancy), 32'd2);
      chk("wrap pc step", id_pc - prev_pc, 32'd4);
      prev_pc = id_pc;
    end
    sb_cycle(1'b0, 1'b0, 32'h0);
    sb_cycle(1'b0, 1'b0, 32'h0);
    chk("drained", {31'b0, id_valid}, 32'h0);

    // Fetch into an empty queue with decode ready.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hBFC00000);
    #1;
`ifdef IFID_BYPASS_EN
    chk("bypass same-cycle valid", {31'b0, id_valid}, 32'h1);
    chk("bypass same-cycle pc", id_pc, 32'hBFC00000);
    step();
    chk("bypass occupancy", 32'(occupancy), 32'd0);
    chk("bypass consumed", {31'b0, id_valid}, 32'h0);
`else
    chk("no-bypass same-cycle valid", {31'b0, id_valid}, 32'h0);
    step();
    chk_head("no-bypass next cycle", 1'b1, 32'hBFC00000, 1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    step();
    chk("no-bypass drained", 32'(occupancy), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
